// File: rtl/div_issue_ctrl_pkg.sv
// Shared definitions for the EX-stage divide issue controller.
// State encoding of the issue FSM and the bit split of the divider result word.
// No logic lives here.
package div_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        DIVC_IDLE = 2'd0,
        DIVC_BUSY = 2'd1,
        DIVC_DONE = 2'd2
    } divc_state_e;

    // Divider result word: quotient in the upper half, remainder in the lower half.
    localparam int QUOT_MSB = 63;
    localparam int QUOT_LSB = 32;
    localparam int REM_MSB  = 31;
    localparam int REM_LSB  = 0;

endpackage

// File: rtl/div_watchdog.sv
// Watchdog for a divide in flight: counts enabled cycles since the last clear.
// expire_o is combinational and fires on the TIMEOUT_CYCLES-th enabled cycle.
// No backpressure; the owner decides what to do with the pulse.
module div_watchdog #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The current cycle is the last allowed one when the count already holds TIMEOUT-1.
    assign expire_o = en_i & ~clr_i & (cnt_q == CNT_LAST);

    // Clear wins over counting so a fresh operation always starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Sequences the shared divider for DIV/DIVU in EX: latches operands, drives start/annul,
// stalls the pipe from issue until the result is held (divider latency + 1; divide-by-zero 1).
// Result is offered on hilo_we_o until stall_i drops; flush kills the instruction at any point.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_valid_i,
    input  logic        ex_div_signed_i,
    input  logic [31:0] ex_op1_i,
    input  logic [31:0] ex_op2_i,
    input  logic        flush_i,
    input  logic        stall_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        stallreq_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        timeout_o
);

    divc_state_e state_q, state_d;
    logic        start_q, start_d;
    logic        signed_q, signed_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic wd_clr;
    logic wd_en;
    logic wd_expire;

    // Only BUSY cycles that neither complete nor get flushed count towards a hang.
    assign wd_clr = (state_q != DIVC_BUSY);
    assign wd_en  = (state_q == DIVC_BUSY) & ~flush_i & ~div_ready_i;

    div_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .expire_o (wd_expire)
    );

    assign div_start_o  = start_q;
    assign div_signed_o = signed_q;
    assign div_op1_o    = op1_q;
    assign div_op2_o    = op2_q;
    assign hilo_we_o    = (state_q == DIVC_DONE);
    // hi/lo registers are cleared on every exit from DONE, so they read 0 whenever hilo_we_o is low.
    assign hi_o         = hi_q;
    assign lo_o         = lo_q;
    assign timeout_o    = wd_expire;
    // Cancel the divider when the in-flight op is killed by flush or abandoned by the watchdog.
    assign div_annul_o  = (state_q == DIVC_BUSY) & (flush_i | wd_expire);
    assign stallreq_o   = ex_div_valid_i & ~flush_i & (state_q != DIVC_DONE);

    // Next-state logic: flush overrides completion, timeout and new issue.
    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        signed_d = signed_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        if (flush_i) begin
            state_d = DIVC_IDLE;
            start_d = 1'b0;
            hi_d    = '0;
            lo_d    = '0;
        end else begin
            case (state_q)
                DIVC_IDLE: begin
                    if (ex_div_valid_i) begin
                        if (ex_op2_i != 32'd0) begin
                            state_d  = DIVC_BUSY;
                            start_d  = 1'b1;
                            signed_d = ex_div_signed_i;
                            op1_d    = ex_op1_i;
                            op2_d    = ex_op2_i;
                        end else begin
                            // Divide-by-zero is answered locally; the divider is left alone.
                            state_d = DIVC_DONE;
                            hi_d    = '0;
                            lo_d    = '0;
                        end
                    end
                end
                DIVC_BUSY: begin
                    if (div_ready_i) begin
                        state_d = DIVC_DONE;
                        hi_d    = div_result_i[REM_MSB:REM_LSB];
                        lo_d    = div_result_i[QUOT_MSB:QUOT_LSB];
                    end else if (wd_expire) begin
                        // Back to IDLE; the instruction is still in EX and reissues from there.
                        state_d = DIVC_IDLE;
                        start_d = 1'b0;
                    end
                end
                DIVC_DONE: begin
                    // start stays high while held so the divider keeps its result.
                    if (!stall_i) begin
                        state_d = DIVC_IDLE;
                        start_d = 1'b0;
                        hi_d    = '0;
                        lo_d    = '0;
                    end
                end
                default: begin
                    state_d = DIVC_IDLE;
                    start_d = 1'b0;
                    hi_d    = '0;
                    lo_d    = '0;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DIVC_IDLE;
            start_q  <= 1'b0;
            signed_q <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            signed_q <= signed_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

endmodule
